dsec_seq_ctrl: RTL and testbench
================================

// Module: dsec_seq_ctrl
// PURPOSE
//  Sequencing controller for the DSEC stream path (compression -> shift-concat -> encryption -> output).
//  Gates input into the compression module and holds each 64-bit output word until the receiver acks it.
//  Issues the end-of-stream flush (dump) to the compression module and reports faults on a sticky error code.
//  Sits between the top-level bus pins and the compression and shift-concat modules.
// PARAMETERS
//  TMO_W    8    width of the output-hold timeout counter
//  TMO_MAX  200  cycles out_valid may wait unacked before fault 0x03 (needs DSEC_HOLD_TMO_EN)
// PORTS
//  clk            in   1   system clock; all state updates on posedge
//  rst            in   1   asynchronous, active-high reset
//  key_config     in   1   encryption keys being configured
//  in_valid       in   1   valid input word on bus
//  in_last        in   1   qualifies in_valid: final word of stream
//  comp_rdy       in   1   compression module can accept input
//  valid_bits     in   7   valid bits held in the compression output (0..64)
//  scon_done      in   1   shift-concat has a complete 64-bit word (1-cycle pulse)
//  out_rcvd       in   1   receiver ack of current output word
//  err_clr        in   1   clears ERR state and error_code
//  valid_to_comp  out  1   input strobe to compression module (comb)
//  rdy            out  1   DSEC ready for input (comb)
//  stall          out  1   all datapath modules hold state (comb)
//  dump_comp      out  1   1-cycle flush command to compression (reg)
//  out_valid      out  1   output word valid (reg)
//  error          out  1   fault present (reg)
//  error_code     out  8   last fault code, sticky (reg)
// BEHAVIOUR
//  Reset values: state=IDLE, out_valid=0, dump_comp=0, error=0, error_code=8'h00, last_seen=0.
//  While rst=1: stall=1, rdy=0, valid_to_comp=0. Reset mid-stream drops any held word; no flush is issued.
//  Comb outputs: rdy = comp_rdy & (state==IDLE|RUN); valid_to_comp = in_valid & rdy & ~key_config;
//    stall = ~valid_to_comp | (out_valid & ~out_rcvd) | error.
//  FSM states: IDLE, KEYCFG, RUN, HOLD, FLUSH, ERR.
//  IDLE:   key_config -> KEYCFG; valid_to_comp -> RUN.
//  KEYCFG: key_config=0 -> IDLE. in_valid=1 while in KEYCFG is ignored; no fault is raised.
//  RUN:    in_valid & ~comp_rdy -> ERR, code 0x02 (overrun). key_config=1 -> ERR, code 0x04.
//          An accepted word with in_last=1 sets last_seen. scon_done -> HOLD, and out_valid=1 on the next edge.
//          last_seen & ~scon_done -> FLUSH.
//          If scon_done and the last accept coincide, HOLD takes priority and last_seen is still set.
//  HOLD:   out_valid stays 1 until out_rcvd is sampled 1, then out_valid=0 on the next edge.
//          Exit on ack: last_seen=0 -> RUN; last_seen & ~flushed -> FLUSH; flushed -> IDLE (clears last_seen and flushed).
//          out_rcvd asserted outside HOLD is ignored.
//  FLUSH:  On entry, if valid_bits==0: go directly to IDLE with no dump.
//          Otherwise dump_comp=1 for exactly one cycle on entry, set flushed, then wait for scon_done -> HOLD.
//  ERR:    error=1, stall=1, and error_code holds the first fault (later faults do not overwrite it).
//          err_clr -> IDLE, error=0, error_code=0x00, last_seen=0, flushed=0.
//  Fault priority within one cycle: 0x04 > 0x02 > 0x03.
//  Latency: scon_done -> out_valid = 1 cycle. out_rcvd -> out_valid low = 1 cycle.
//    flush entry -> dump_comp = 1 cycle.
// CONFIGURATION
//  DSEC_HOLD_TMO_EN defined:
//    TMO_W-bit counter clears on HOLD entry and increments each cycle in HOLD while out_rcvd=0.
//    When the count reaches TMO_MAX -> ERR, code 0x03. An ack in the same cycle wins (no fault).
//  Not defined: HOLD waits indefinitely; the counter and code 0x03 are not synthesized.
// STRUCTURE
//  Package dsec_ctrl_pkg: state enum; fault localparams ERR_NONE=0x00, ERR_OVERRUN=0x02, ERR_TMO=0x03, ERR_KEYCFG=0x04.
//  Sub-module dsec_hold_tmr: clear / enable / expired timeout counter, instantiated only under DSEC_HOLD_TMO_EN.
// TESTING
//  1. Reset, then key_config=1 for 5 cycles, then 0 -> stall=1 throughout; FSM returns to IDLE; error=0.
//  2. Stream 3 words with in_last on the 3rd, scon_done after word 2, ack 2 cycles later
//     -> out_valid high 3 cycles; FLUSH entered; dump_comp exactly 1 pulse.
//  3. Flush with valid_bits=0 -> no dump_comp pulse; IDLE 1 cycle after FLUSH entry.
//  4. In RUN, in_valid=1 with comp_rdy=0 -> error=1 and error_code=0x02 next edge;
//     a later key_config=1 leaves the code at 0x02; err_clr returns to IDLE.
//  5. DSEC_HOLD_TMO_EN with TMO_MAX=200, out_rcvd held 0 -> error_code=0x03 at HOLD cycle 200;
//     repeat with an ack at cycle 200 -> no fault.
//  6. Assert rst while out_valid=1 -> out_valid=0 immediately (async); stall=1 and rdy=0 until rst is released.

Source files
------------

// File: rtl/dsec_ctrl_pkg.sv
// Shared types for the DSEC sequencing controller: FSM state encoding and fault codes.
package dsec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYCFG = 3'd1,
    ST_RUN    = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam logic [7:0] ERR_NONE    = 8'h00;
  localparam logic [7:0] ERR_OVERRUN = 8'h02;
  localparam logic [7:0] ERR_TMO     = 8'h03;
  localparam logic [7:0] ERR_KEYCFG  = 8'h04;

  // Same-cycle faults resolve as keycfg > overrun > timeout.
  function automatic logic [7:0] fault_pick(input logic kcfg, input logic ovr, input logic tmo);
    if (kcfg) return ERR_KEYCFG;
    if (ovr)  return ERR_OVERRUN;
    if (tmo)  return ERR_TMO;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dsec_hold_tmr.sv
// Output-hold timeout counter: cleared outside HOLD, counts unacked HOLD cycles, flags the last allowed one.
module dsec_hold_tmr #(
  parameter int W   = 8,
  parameter int MAX = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  // High in the cycle whose unacked edge would bring the count to MAX.
  assign expired = en & ~clr & (count == LAST);

endmodule

// File: rtl/dsec_seq_ctrl.sv
// DSEC sequencing controller: gates input to compression, holds output words until acked, issues flush, reports faults.
// Define DSEC_HOLD_TMO_EN to build the output-hold timeout (fault 0x03).
module dsec_seq_ctrl
  import dsec_ctrl_pkg::*;
#(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_config,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       comp_rdy,
  input  logic [6:0] valid_bits,
  input  logic       scon_done,
  input  logic       out_rcvd,
  input  logic       err_clr,
  output logic       valid_to_comp,
  output logic       rdy,
  output logic       stall,
  output logic       dump_comp,
  output logic       out_valid,
  output logic       error,
  output logic [7:0] error_code
);

  localparam bit TMO_CFG_OK = (TMO_W >= 1) && (TMO_MAX >= 1) && (TMO_MAX < (1 << TMO_W));

  state_t     state;
  logic       last_seen;
  logic       flushed;
  logic       accept;
  logic       fault_kcfg;
  logic       fault_ovr;
  logic       fault_tmo;
  logic [7:0] fault_code;

  assign rdy           = ~rst & comp_rdy & ((state == ST_IDLE) | (state == ST_RUN));
  assign valid_to_comp = in_valid & rdy & ~key_config;
  assign stall         = rst | ~valid_to_comp | (out_valid & ~out_rcvd) | error;
  assign accept        = valid_to_comp;

  assign fault_kcfg = (state == ST_RUN) & key_config;
  assign fault_ovr  = (state == ST_RUN) & in_valid & ~comp_rdy;

`ifdef DSEC_HOLD_TMO_EN
  logic tmr_expired;

  dsec_hold_tmr #(
    .W   (TMO_W),
    .MAX (TMO_MAX)
  ) u_hold_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_HOLD),
    .en      ((state == ST_HOLD) & ~out_rcvd),
    .expired (tmr_expired)
  );

  assign fault_tmo = tmr_expired;
`else
  assign fault_tmo = 1'b0;
`endif

  assign fault_code = fault_pick(fault_kcfg, fault_ovr, fault_tmo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      dump_comp  <= 1'b0;
      error      <= 1'b0;
      error_code <= ERR_NONE;
      last_seen  <= 1'b0;
      flushed    <= 1'b0;
    end else begin
      dump_comp <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (key_config) begin
            state <= ST_KEYCFG;
          end else if (accept) begin
            state <= ST_RUN;
            if (in_last) last_seen <= 1'b1;
          end
        end

        ST_KEYCFG: begin
          if (!key_config) state <= ST_IDLE;
        end

        ST_RUN: begin
          if (fault_kcfg || fault_ovr) begin
            state      <= ST_ERR;
            error      <= 1'b1;
            error_code <= fault_code;
          end else begin
            if (accept && in_last) last_seen <= 1'b1;
            // A completed word outranks the flush so it is never lost.
            if (scon_done) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
            end else if (last_seen) begin
              state <= ST_FLUSH;
            end
          end
        end

        ST_HOLD: begin
          if (out_rcvd) begin
            out_valid <= 1'b0;
            if (!last_seen) begin
              state <= ST_RUN;
            end else if (!flushed) begin
              state <= ST_FLUSH;
            end else begin
              state     <= ST_IDLE;
              last_seen <= 1'b0;
              flushed   <= 1'b0;
            end
          end else if (fault_tmo) begin
            state      <= ST_ERR;
            out_valid  <= 1'b0;
            error      <= 1'b1;
            error_code <= fault_code;
          end
        end

        ST_FLUSH: begin
          // flushed=0 marks the entry cycle: decide between dump and direct exit.
          if (!flushed) begin
            if (valid_bits == 7'd0) begin
              state     <= ST_IDLE;
              last_seen <= 1'b0;
            end else begin
              dump_comp <= 1'b1;
              flushed   <= 1'b1;
            end
          end else if (scon_done) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
          end
        end

        ST_ERR: begin
          if (err_clr) begin
            state      <= ST_IDLE;
            error      <= 1'b0;
            error_code <= ERR_NONE;
            last_seen  <= 1'b0;
            flushed    <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  a_tmo_cfg:     assert property (@(posedge clk) TMO_CFG_OK);
  a_dump_single: assert property (@(posedge clk) disable iff (rst) dump_comp |=> !dump_comp);
  a_ov_in_hold:  assert property (@(posedge clk) disable iff (rst) out_valid |-> (state == ST_HOLD));
  a_err_state:   assert property (@(posedge clk) disable iff (rst) error == (state == ST_ERR));

endmodule

// File: tb/tb_dsec_seq_ctrl.sv
// Randomized self-checking bench for dsec_seq_ctrl using a transaction-level timing model.
module tb_dsec_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_config;
  logic       in_valid;
  logic       in_last;
  logic       comp_rdy;
  logic [6:0] valid_bits;
  logic       scon_done;
  logic       out_rcvd;
  logic       err_clr;
  logic       valid_to_comp;
  logic       rdy;
  logic       stall;
  logic       dump_comp;
  logic       out_valid;
  logic       error;
  logic [7:0] error_code;

  int n_checks = 0;
  int n_fail   = 0;
  int ov_seen  = 0;
  int dump_seen = 0;
  int exp_ov   = 0;
  int exp_dump = 0;

  always #5 clk = ~clk;

  dsec_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .key_config    (key_config),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .comp_rdy      (comp_rdy),
    .valid_bits    (valid_bits),
    .scon_done     (scon_done),
    .out_rcvd      (out_rcvd),
    .err_clr       (err_clr),
    .valid_to_comp (valid_to_comp),
    .rdy           (rdy),
    .stall         (stall),
    .dump_comp     (dump_comp),
    .out_valid     (out_valid),
    .error         (error),
    .error_code    (error_code)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) ov_seen++;
      if (dump_comp) dump_seen++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic iv, input logic il, input logic sd, input logic ack);
    in_valid  = iv;
    in_last   = il;
    scon_done = sd;
    out_rcvd  = ack;
    #1;
  endtask

  // Word presented; out_valid must stay up for d unacked cycles plus the ack cycle.
  task automatic hold_word(input int d);
    for (int i = 0; i < d; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("hold_ov", out_valid, 1);
      check_eq("hold_rdy", rdy, 0);
      check_eq("hold_stall", stall, 1);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("ack_ov", out_valid, 1);
    tick();
    exp_ov += d + 1;
  endtask

  // In IDLE an unready in_valid is harmless; in RUN it would fault.
  task automatic probe_idle();
    comp_rdy = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("probe_rdy", rdy, 0);
    tick();
    comp_rdy = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("probe_noerr", error, 0);
    check_eq("probe_idle_rdy", rdy, 1);
    check_eq("probe_ov", out_valid, 0);
    tick();
  endtask

  // Called in the first FLUSH cycle.
  task automatic flush_tail(input int vb, input int ack_d2);
    int w2;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("flush_rdy", rdy, 0);
    check_eq("flush_nodump", dump_comp, 0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    if (vb == 0) begin
      check_eq("flush0_idle", rdy, 1);
      check_eq("flush0_nodump", dump_comp, 0);
      probe_idle();
    end else begin
      check_eq("dump_pulse", dump_comp, 1);
      check_eq("dump_rdy", rdy, 0);
      exp_dump++;
      tick();
      w2 = $urandom_range(0, 3);
      for (int i = 0; i < w2; i++) begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("dump_wait", dump_comp, 0);
        check_eq("dump_wait_ov", out_valid, 0);
        tick();
      end
      set_in(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("dump_end", dump_comp, 0);
      tick();
      hold_word(ack_d2);
      probe_idle();
    end
  endtask

  // sc_pos: 0 none, 1..n-1 scon_done after that word, n scon_done with the last accept.
  task automatic run_stream(input int n, input int sc_pos, input int ack_d, input int vb, input int ack_d2);
    int gap;
    valid_bits = 7'(vb);
    for (int w = 1; w <= n; w++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        set_in(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        check_eq("gap_rdy", rdy, 1);
        check_eq("gap_ov", out_valid, 0);
        check_eq("gap_stall", stall, 1);
        tick();
      end
      set_in(1'b1, (w == n), (sc_pos == n) && (w == n), 1'b0);
      check_eq("acc_vtc", valid_to_comp, 1);
      check_eq("acc_stall", stall, 0);
      tick();
      if (w == sc_pos && w < n) begin
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("scon_rdy", rdy, 1);
        tick();
        hold_word(ack_d);
      end
    end
    if (sc_pos == n) begin
      hold_word(ack_d);
    end else begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("last_run_rdy", rdy, 1);
      check_eq("last_nodump", dump_comp, 0);
      tick();
    end
    flush_tail(vb, ack_d2);
  endtask

  task automatic enter_hold();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("eh_acc", valid_to_comp, 1);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  // kind 0: overrun, 1: keycfg fault (maybe with overrun), 2: keycfg fault right after an in_last accept.
  task automatic fault_test(input int kind);
    int extra;
    comp_rdy = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    extra = $urandom_range(0, 2);
    for (int i = 0; i < extra; i++) begin
      set_in(1'b1, (kind == 2) && (i == extra - 1), 1'b0, 1'b0);
      tick();
    end
    if (kind == 2 && extra == 0) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    if (kind == 0) begin
      comp_rdy = 1'b0;
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("ovr_vtc", valid_to_comp, 0);
      check_eq("ovr_pre_err", error, 0);
      tick();
      comp_rdy = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("ovr_err", error, 1);
      check_eq("ovr_code", error_code, 8'h02);
      check_eq("ovr_stall", stall, 1);
      check_eq("ovr_rdy", rdy, 0);
      key_config = 1'b1;
      #1;
      tick();
      key_config = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("ovr_code_sticky", error_code, 8'h02);
    end else begin
      key_config = 1'b1;
      if (kind == 1 && $urandom_range(0, 1) == 1) begin
        comp_rdy = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
      end
      tick();
      key_config = 1'b0;
      comp_rdy   = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("kc_err", error, 1);
      check_eq("kc_code", error_code, 8'h04);
    end
    err_clr = 1'b1;
    #1;
    tick();
    err_clr = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("clr_err", error, 0);
    check_eq("clr_code", error_code, 8'h00);
    check_eq("clr_rdy", rdy, 1);
    run_stream(2, 0, 0, 0, 0);
  endtask

  task automatic hold_199(input string tag);
    logic bad;
    bad = 1'b0;
    enter_hold();
    for (int c = 1; c < 200; c++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      if (error || !out_valid) bad = 1'b1;
      tick();
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov0, d0, n, sc, vb, base_dump;
    rst = 1'b1; key_config = 1'b0; in_valid = 1'b1; in_last = 1'b0; comp_rdy = 1'b1;
    valid_bits = 7'd0; scon_done = 1'b0; out_rcvd = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_eq("rst_ov", out_valid, 0);
    check_eq("rst_dump", dump_comp, 0);
    check_eq("rst_err", error, 0);
    check_eq("rst_code", error_code, 8'h00);
    check_eq("rst_stall", stall, 1);
    check_eq("rst_rdy", rdy, 0);
    check_eq("rst_vtc", valid_to_comp, 0);
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_rdy", rdy, 1);

    // Key configuration: no input accepted, stall held, no fault.
    for (int i = 0; i < 5; i++) begin
      key_config = 1'b1;
      set_in(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      check_eq("kcfg_stall", stall, 1);
      check_eq("kcfg_vtc", valid_to_comp, 0);
      if (i > 0) check_eq("kcfg_rdy", rdy, 0);
      tick();
    end
    key_config = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("kcfg_exit_rdy", rdy, 0);
    check_eq("kcfg_err", error, 0);
    tick();
    probe_idle();

    ov0 = ov_seen; d0 = dump_seen;
    run_stream(3, 2, 2, 37, 1);
    check_eq("t2_ov_cycles", ov_seen - ov0, 3 + 2);
    check_eq("t2_dumps", dump_seen - d0, 1);

    d0 = dump_seen;
    run_stream(2, 0, 0, 0, 0);
    check_eq("t3_dumps", dump_seen - d0, 0);

    ov0 = ov_seen; d0 = dump_seen; exp_ov = 0; exp_dump = 0;
    for (int it = 0; it < 25; it++) begin
      n  = $urandom_range(2, 5);
      sc = $urandom_range(0, n);
      vb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 64) : 0;
      run_stream(n, sc, $urandom_range(0, 4), vb, $urandom_range(0, 4));
    end
    check_eq("sb_ov_cycles", ov_seen - ov0, exp_ov);
    check_eq("sb_dumps", dump_seen - d0, exp_dump);

    fault_test(0);
    fault_test(1);
    fault_test(2);

`ifdef DSEC_HOLD_TMO_EN
    hold_199("tmo_pre");
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tmo_err", error, 1);
    check_eq("tmo_code", error_code, 8'h03);
    check_eq("tmo_ov", out_valid, 0);
    err_clr = 1'b1;
    #1;
    tick();
    err_clr = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tmo_clr", error_code, 8'h00);
    hold_199("tmo_pre2");
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tmo_ack_noerr", error, 0);
    check_eq("tmo_ack_ov", out_valid, 0);
    check_eq("tmo_ack_rdy", rdy, 1);
    run_stream(1, 0, 0, 0, 0);
`else
    hold_199("hold_long_pre");
    for (int c = 0; c < 60; c++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_long_noerr", error, 0);
    check_eq("hold_long_ov", out_valid, 1);
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_long_exit", out_valid, 0);
    check_eq("hold_long_rdy", rdy, 1);
    run_stream(1, 0, 0, 0, 0);
`endif

    // Asynchronous reset while a word is held.
    enter_hold();
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("prerst_ov", out_valid, 1);
    base_dump = dump_seen;
    rst = 1'b1;
    #1;
    check_eq("arst_ov", out_valid, 0);
    check_eq("arst_stall", stall, 1);
    check_eq("arst_rdy", rdy, 0);
    check_eq("arst_vtc", valid_to_comp, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #3;
      check_eq("rsthold_stall", stall, 1);
      check_eq("rsthold_rdy", rdy, 0);
    end
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rel_rdy", rdy, 1);
    check_eq("rel_ov", out_valid, 0);
    for (int i = 0; i < 4; i++) tick();
    check_eq("rel_no_dump", dump_seen - base_dump, 0);
    probe_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
